multi_dataflow_reconf_ctrl: RTL and testbench

Job sequencer for the multi-dataflow reconfigurable datapath. It accepts jobs (kernel ID, input beat count, output beat count) over a valid/ready request port and sets the kernel ID with a settle delay whenever the ID changes. It issues the one-cycle kernel start, gates the input stream to exactly the job's input count, and waits for the job's output count. It then reports completion, or a timeout if the stream stalls. It sits between the HWPE controller/register file and the kernel adapter, and it drives the adapter's `ID` and `ctrl_i.start`.

---
 rtl/multi_dataflow_reconf_ctrl_pkg.sv | 24 ++
 rtl/multi_dataflow_reconf_ctrl_beat_counter.sv | 41 ++++
 rtl/multi_dataflow_reconf_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multi_dataflow_reconf_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/multi_dataflow_reconf_ctrl_pkg.sv
// Shared types and defaults for the multi-dataflow job sequencer.
// Imported by the reconfiguration controller and its beat counters.
package multi_dataflow_package;

    localparam int unsigned RECONF_CTRL_CNT_W   = 16;
    localparam int unsigned RECONF_CTRL_CYCLES  = 4;
    localparam int unsigned RECONF_CTRL_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        RC_IDLE,
        RC_RECONF,
        RC_START,
        RC_RUN,
        RC_DRAIN,
        RC_DONE
    } reconf_ctrl_state_t;

    typedef struct packed {
        logic [31:0]                  id;
        logic [RECONF_CTRL_CNT_W-1:0] n_in;
        logic [RECONF_CTRL_CNT_W-1:0] n_out;
    } reconf_job_t;

endpackage

// File: rtl/multi_dataflow_reconf_ctrl_beat_counter.sv
// Saturating beat counter with synchronous clear, enable and limit.
// hit_o flags a beat that is actually counted this cycle.
module multi_dataflow_beat_counter
    import multi_dataflow_package::*;
#(
    parameter int unsigned W = RECONF_CTRL_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         below_o,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign below_o = cnt_q < limit_i;
    assign hit_o   = en_i & below_o;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hit_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dataflow_reconf_ctrl.sv
// Job sequencer: kernel ID reconfiguration, start pulse, input gating,
// output drain and stall watchdog for the multi-dataflow datapath.
module multi_dataflow_reconf_ctrl
    import multi_dataflow_package::*;
#(
    parameter int unsigned CNT_W         = RECONF_CTRL_CNT_W,
    parameter int unsigned RECONF_CYCLES = RECONF_CTRL_CYCLES,
    parameter int unsigned TIMEOUT       = RECONF_CTRL_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [31:0]      job_id_i,
    input  logic [CNT_W-1:0] job_n_in_i,
    input  logic [CNT_W-1:0] job_n_out_i,
    input  logic             in_valid_i,
    input  logic             in_ready_i,
    input  logic             out_valid_i,
    input  logic             out_ready_i,
    output logic             in_gate_o,
    output logic [31:0]      kernel_id_o,
    output logic             kernel_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cnt_in_o,
    output logic [CNT_W-1:0] cnt_out_o
);

    localparam int unsigned RC_W = (RECONF_CYCLES > 1) ? $clog2(RECONF_CYCLES + 1) : 1;
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECONF_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    reconf_ctrl_state_t state_q;
    reconf_job_t        job_q;
    logic               id_valid_q;
    logic               to_q;
    logic [RC_W-1:0]    settle_q;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic             accept, running;
    logic             in_en, in_hit, in_below;
    logic             out_en, out_hit, out_below;
    logic             in_met, out_met, wd_exp;
    logic [CNT_W-1:0] n_in, n_out, in_next, out_next;

    assign n_in    = CNT_W'(job_q.n_in);
    assign n_out   = CNT_W'(job_q.n_out);
    assign accept  = job_valid_i && (state_q == RC_IDLE);
    assign running = (state_q == RC_RUN) || (state_q == RC_DRAIN);

    assign in_gate_o = (state_q == RC_RUN) && in_below;
    assign in_en     = in_valid_i & in_ready_i & in_gate_o;
    assign out_en    = out_valid_i & out_ready_i & running;

    multi_dataflow_beat_counter #(.W(CNT_W)) u_in_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (accept),
        .en_i    (in_en),
        .limit_i (n_in),
        .cnt_o   (cnt_in_o),
        .below_o (in_below),
        .hit_o   (in_hit)
    );

    multi_dataflow_beat_counter #(.W(CNT_W)) u_out_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (accept),
        .en_i    (out_en),
        .limit_i (n_out),
        .cnt_o   (cnt_out_o),
        .below_o (out_below),
        .hit_o   (out_hit)
    );

    // Completion includes the beat counted in the current cycle.
    assign in_next  = cnt_in_o + CNT_W'(in_hit);
    assign out_next = cnt_out_o + CNT_W'(out_hit);
    assign in_met   = in_next == n_in;
    assign out_met  = out_next == n_out;

    always_comb begin
        wd_d = wd_q;
        if (in_hit || out_hit) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    assign wd_exp = (TIMEOUT != 0) && (wd_d == WD_MAX);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RC_IDLE;
            job_q      <= '0;
            id_valid_q <= 1'b0;
            to_q       <= 1'b0;
            settle_q   <= '0;
            wd_q       <= '0;
        end else begin
            to_q <= 1'b0;
            unique case (state_q)
                RC_IDLE: begin
                    if (accept) begin
                        job_q.n_in  <= RECONF_CTRL_CNT_W'(job_n_in_i);
                        job_q.n_out <= RECONF_CTRL_CNT_W'(job_n_out_i);
                        if (id_valid_q && (job_id_i == job_q.id)) begin
                            state_q <= RC_START;
                        end else begin
                            job_q.id   <= job_id_i;
                            id_valid_q <= 1'b1;
                            settle_q   <= RC_LOAD;
                            state_q    <= RC_RECONF;
                        end
                    end
                end
                RC_RECONF: begin
                    if (settle_q == RC_W'(1)) begin
                        state_q <= RC_START;
                    end else begin
                        settle_q <= settle_q - RC_W'(1);
                    end
                end
                RC_START: begin
                    wd_q    <= '0;
                    state_q <= RC_RUN;
                end
                RC_RUN: begin
                    wd_q <= wd_d;
                    if (in_met && out_met) begin
                        state_q <= RC_DONE;
                    end else if (in_met) begin
                        state_q <= RC_DRAIN;
                    end else if (wd_exp) begin
                        to_q       <= 1'b1;
                        id_valid_q <= 1'b0;
                        state_q    <= RC_DONE;
                    end
                end
                RC_DRAIN: begin
                    wd_q <= wd_d;
                    if (out_met) begin
                        state_q <= RC_DONE;
                    end else if (wd_exp) begin
                        to_q       <= 1'b1;
                        id_valid_q <= 1'b0;
                        state_q    <= RC_DONE;
                    end
                end
                RC_DONE: begin
                    state_q <= RC_IDLE;
                end
                default: begin
                    state_q <= RC_IDLE;
                end
            endcase
        end
    end

    assign job_ready_o    = state_q == RC_IDLE;
    assign busy_o         = state_q != RC_IDLE;
    assign kernel_start_o = state_q == RC_START;
    assign done_o         = state_q == RC_DONE;
    assign timeout_o      = to_q;
    assign kernel_id_o    = job_q.id;

endmodule

// File: tb/tb_multi_dataflow_reconf_ctrl.sv
// Directed bench for the multi-dataflow job sequencer.
module tb_multi_dataflow_reconf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic [31:0] job_id;
    logic [15:0] job_n_in, job_n_out;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        job_ready_o, in_gate_o, kernel_start_o;
    logic        busy_o, done_o, timeout_o;
    logic [31:0] kernel_id_o;
    logic [15:0] cnt_in_o, cnt_out_o;

    int errors = 0;
    int checks = 0;
    int r_start, r_done, r_beats, r_dones, r_tos, r_tonly, r_chg;
    logic [15:0] r_cin, r_cout;

    multi_dataflow_reconf_ctrl #(
        .CNT_W(16), .RECONF_CYCLES(4), .TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready_o),
        .job_id_i(job_id), .job_n_in_i(job_n_in), .job_n_out_i(job_n_out),
        .in_valid_i(in_valid), .in_ready_i(in_ready),
        .out_valid_i(out_valid), .out_ready_i(out_ready),
        .in_gate_o(in_gate_o), .kernel_id_o(kernel_id_o),
        .kernel_start_o(kernel_start_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o),
        .cnt_in_o(cnt_in_o), .cnt_out_o(cnt_out_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers one job, then watches cycles k=1.. after the accept edge
    // until job_ready returns; outputs are offered from the first RUN cycle.
    task automatic run_job(input logic [31:0] id, input logic [15:0] ni,
                           input logic [15:0] no, input int obud);
        int offered;
        bit go, fin;
        logic [15:0] pci, pco;
        offered = 0; go = 0; fin = 0;
        r_start = -1; r_done = -1; r_beats = 0; r_dones = 0;
        r_tos = 0; r_tonly = 0; r_chg = 0; r_cin = '0; r_cout = '0;
        job_id = id; job_n_in = ni; job_n_out = no; job_valid = 1'b1;
        chk("accept_ready", job_ready_o, 1);
        tick();
        job_valid = 1'b0;
        pci = cnt_in_o; pco = cnt_out_o;
        for (int k = 1; k <= 80 && !fin; k++) begin
            if (cnt_in_o !== pci || cnt_out_o !== pco) r_chg = k;
            pci = cnt_in_o; pco = cnt_out_o;
            if (kernel_start_o && r_start < 0) r_start = k;
            if (in_gate_o && in_valid && in_ready) r_beats++;
            if (timeout_o) begin
                r_tos++;
                if (!done_o) r_tonly++;
            end
            if (done_o) begin
                r_dones++; r_done = k; r_cin = cnt_in_o; r_cout = cnt_out_o;
            end
            if (job_ready_o) begin
                fin = 1;
            end else begin
                out_valid = go && (offered < obud);
                if (out_valid && out_ready) offered++;
                if (kernel_start_o) go = 1;
                tick();
            end
        end
        out_valid = 1'b0;
        chk("job_finished", 32'(fin), 1);
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_id = '0;
        job_n_in = '0; job_n_out = '0;
        in_valid = 1'b0; in_ready = 1'b1; out_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tick();
        chk("rst_ready", job_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_kid", kernel_id_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt_in", cnt_in_o, 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();

        // first job after reset: 4 settle cycles, then 8 in / 2 out
        run_job(32'd3, 16'd8, 16'd2, 100);
        chk("a_start", r_start, 5);
        chk("a_kid", kernel_id_o, 3);
        chk("a_beats", r_beats, 8);
        chk("a_dones", r_dones, 1);
        chk("a_done_k", r_done, 14);
        chk("a_cin", r_cin, 8);
        chk("a_cout", r_cout, 2);

        // same ID: no reconfiguration
        run_job(32'd3, 16'd2, 16'd1, 100);
        chk("b_start", r_start, 1);
        chk("b_done_k", r_done, 4);

        // new ID: reconfigure again
        run_job(32'd5, 16'd2, 16'd1, 100);
        chk("c_start", r_start, 5);
        chk("c_kid", kernel_id_o, 5);
        chk("c_done_k", r_done, 8);

        // zero-length job: START, RUN, DONE
        run_job(32'd5, 16'd0, 16'd0, 0);
        chk("z_start", r_start, 1);
        chk("z_done_k", r_done, 3);
        chk("z_beats", r_beats, 0);
        chk("z_cout", r_cout, 0);

        // output stalls after 2 of 4 beats
        run_job(32'd5, 16'd4, 16'd4, 2);
        chk("t_timeouts", r_tos, 1);
        chk("t_to_alone", r_tonly, 0);
        chk("t_done_k", r_done, 22);
        chk("t_idle_span", r_done - r_chg, 16);
        chk("t_cin", r_cin, 4);
        chk("t_cout", r_cout, 2);

        // the aborted ID is no longer trusted
        run_job(32'd5, 16'd1, 16'd1, 5);
        chk("r_start", r_start, 5);
        chk("r_done_k", r_done, 7);
        chk("r_timeouts", r_tos, 0);

        // reset in the middle of RUN
        job_id = 32'd5; job_n_in = 16'd10; job_n_out = 16'd1; job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("m_start", kernel_start_o, 1);
        tick(); tick(); tick(); tick();
        chk("m_cnt_in", cnt_in_o, 3);
        chk("m_gate", in_gate_o, 1);
        rst_n = 1'b0;
        tick();
        chk("m_ready", job_ready_o, 1);
        chk("m_busy", busy_o, 0);
        chk("m_gate0", in_gate_o, 0);
        chk("m_kid", kernel_id_o, 0);
        chk("m_cnt0", cnt_in_o, 0);
        chk("m_start0", kernel_start_o, 0);
        rst_n = 1'b1;
        run_job(32'd5, 16'd1, 16'd1, 5);
        chk("m_reconf", r_start, 5);
        chk("m_kid5", kernel_id_o, 5);

        // surplus outputs are not counted
        run_job(32'd5, 16'd6, 16'd2, 5);
        chk("s_start", r_start, 1);
        chk("s_done_k", r_done, 8);
        chk("s_dones", r_dones, 1);
        chk("s_cin", r_cin, 6);
        chk("s_cout", r_cout, 2);
        out_valid = 1'b1;
        tick(); tick();
        out_valid = 1'b0;
        chk("s_idle_cout", cnt_out_o, 2);
        chk("s_idle_done", done_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
